// File: rtl/mmio_console_pkg.sv
// Shared constants for the MMIO console transmitter: register offsets and bit positions.
// Optional macro MMIO_CONSOLE_IRQ_EN (see mmio_console_tx) uses CTRL_IRQ_EN.
package mmio_console_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CTRL    = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_DRAIN   = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_DRAIN  = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with flush; a push into a full FIFO is accepted only
// when a pop happens on the same edge. dout reads 0 while empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PW-1:0]    r_rd, r_wr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop, w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_W'(DEPTH));
  assign count  = r_count;
  assign dout   = empty ? '0 : r_mem[r_rd];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= din;
  end

  // Flush overrides everything on its edge, including a concurrent pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_console_tx.sv
// Memory-mapped console transmitter: 4-word register window feeding a byte FIFO that
// drains over valid/ready. Define MMIO_CONSOLE_IRQ_EN to add the irq output and CTRL.irq_en.
module mmio_console_tx
  import mmio_console_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        r_en,
  input  logic        w_en,
  input  logic [15:0] w_data,
  output logic [15:0] r_data,
  output logic        sel,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
`ifdef MMIO_CONSOLE_IRQ_EN
  ,
  output logic        irq
`endif
);
  logic [15:0]      r_rdata, r_scratch;
  logic             r_drain_en, r_ovf, r_irq_en;
  logic             w_sel, w_wr, w_rd, w_push, w_pop, w_flush;
  logic             w_empty, w_full;
  logic [1:0]       w_off;
  logic [CNT_W-1:0] w_count;
  logic [15:0]      w_status, w_ctrl, w_rmux;

  assign w_sel   = (addr[15:2] == BASE_ADDR[15:2]);
  assign w_off   = addr[1:0];
  assign w_wr    = w_en & w_sel;
  assign w_rd    = r_en & w_sel & ~w_en;
  assign w_push  = w_wr && (w_off == OFF_TXDATA);
  assign w_flush = w_wr && (w_off == OFF_CTRL) && w_data[CTRL_FLUSH];
  assign w_pop   = tx_valid & tx_ready;

  assign sel      = w_sel;
  assign tx_valid = r_drain_en & ~w_empty;
  assign r_data   = r_rdata;

  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (w_data[7:0]),
    .dout  (tx_data),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  always_comb begin
    w_status                         = '0;
    w_status[ST_EMPTY]               = w_empty;
    w_status[ST_FULL]                = w_full;
    w_status[ST_OVF]                 = r_ovf;
    w_status[ST_DRAIN]               = r_drain_en;
    w_status[ST_CNT_LSB +: 8]        = 8'(w_count);
    w_ctrl                           = '0;
    w_ctrl[CTRL_DRAIN]               = r_drain_en;
    w_ctrl[CTRL_IRQ_EN]              = r_irq_en;
    case (w_off)
      OFF_STATUS:  w_rmux = w_status;
      OFF_CTRL:    w_rmux = w_ctrl;
      OFF_SCRATCH: w_rmux = r_scratch;
      default:     w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata    <= '0;
      r_scratch  <= '0;
      r_drain_en <= 1'b1;
      r_ovf      <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_rmux;
      if (w_wr && w_off == OFF_SCRATCH) r_scratch <= w_data;
      if (w_wr && w_off == OFF_CTRL) r_drain_en <= w_data[CTRL_DRAIN];
      // Drop-on-full is the only way to set overflow; W1C is on a different offset.
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr && w_off == OFF_STATUS && w_data[ST_OVF]) r_ovf <= 1'b0;
    end
  end

`ifdef MMIO_CONSOLE_IRQ_EN
  logic r_irq;
  assign irq = r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && w_off == OFF_CTRL) r_irq_en <= w_data[CTRL_IRQ_EN];
      r_irq <= r_irq_en & (w_empty | r_ovf);
    end
  end
`else
  assign r_irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_console_tx.sv
// Bench for mmio_console_tx: register-access vector table plus stream scoreboard sequences.
module tb_mmio_console_tx;
  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = '0;
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [15:0] w_data = '0;
  logic [15:0] r_data;
  logic        sel, tx_valid, tx_ready = 1'b0;
  logic [7:0]  tx_data;
`ifdef MMIO_CONSOLE_IRQ_EN
  logic        irq;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic        we;
    logic        re;
    logic [15:0] wd;
    logic        xsel;
    logic [15:0] xrd;
  } vec_t;
  vec_t tbl[18];

  mmio_console_tx dut (
    .clk(clk), .reset(reset), .addr(addr), .r_en(r_en), .w_en(w_en),
    .w_data(w_data), .r_data(r_data), .sel(sel), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready)
`ifdef MMIO_CONSOLE_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: the stream is scoreboarded at the falling edge, before the pop edge.
  task automatic cyc();
    @(negedge clk);
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("stream_extra", {8'h00, tx_data}, 16'hxxxx);
      else chk("stream_byte", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; w_data = d; w_en = 1'b1;
    cyc();
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    addr = a; r_en = 1'b1;
    cyc();
    r_en = 1'b0;
    d = r_data;
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    wr(BASE, {8'hA5, b});
    if (keep) exp_q.push_back(b);
  endtask

  task automatic drain(input string name);
    tx_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) cyc();
    chk(name, 16'(exp_q.size()), 16'd0);
    chk({name, "_idle"}, {15'd0, tx_valid}, 16'd0);
    tx_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    tbl[0]  = '{BASE+1, 0, 1, 16'h0000, 1, 16'h0009};
    tbl[1]  = '{BASE+2, 0, 1, 16'h0000, 1, 16'h0001};
    tbl[2]  = '{BASE+0, 0, 1, 16'h0000, 1, 16'h0000};
    tbl[3]  = '{BASE+3, 0, 1, 16'h0000, 1, 16'h0000};
    tbl[4]  = '{BASE+4, 1, 0, 16'h1234, 0, 16'h0000};
    tbl[5]  = '{BASE+3, 0, 1, 16'h0000, 1, 16'h0000};
    tbl[6]  = '{BASE+3, 1, 0, 16'hBEEF, 1, 16'h0000};
    tbl[7]  = '{BASE+3, 0, 1, 16'h0000, 1, 16'hBEEF};
    tbl[8]  = '{BASE+4, 0, 1, 16'h0000, 0, 16'hBEEF};
    tbl[9]  = '{16'h0003, 0, 1, 16'h0000, 0, 16'hBEEF};
    tbl[10] = '{BASE+3, 1, 1, 16'h5A5A, 1, 16'hBEEF};
    tbl[11] = '{BASE+3, 0, 1, 16'h0000, 1, 16'h5A5A};
    tbl[12] = '{BASE+2, 1, 0, 16'hFFFE, 1, 16'h5A5A};
    tbl[13] = '{BASE+2, 0, 1, 16'h0000, 1, 16'h0000};
    tbl[14] = '{BASE+1, 0, 1, 16'h0000, 1, 16'h0001};
    tbl[15] = '{BASE+2, 1, 0, 16'h0001, 1, 16'h0001};
    tbl[16] = '{BASE+1, 1, 0, 16'hFFFF, 1, 16'h0001};
    tbl[17] = '{BASE+1, 0, 1, 16'h0000, 1, 16'h0009};

    #2;
    chk("reset_rdata", r_data, 16'h0000);
    chk("reset_valid", {15'd0, tx_valid}, 16'd0);
    chk("reset_txdata", {8'h00, tx_data}, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      addr = tbl[i].a; w_en = tbl[i].we; r_en = tbl[i].re; w_data = tbl[i].wd;
      #1;
      chk($sformatf("vec%0d_sel", i), {15'd0, sel}, {15'd0, tbl[i].xsel});
      cyc();
      w_en = 1'b0; r_en = 1'b0;
      chk($sformatf("vec%0d_rdata", i), r_data, tbl[i].xrd);
    end

    // Single byte held by backpressure, then released.
    wr(BASE, 16'hAB41);
    exp_q.push_back(8'h41);
    chk("single_valid", {15'd0, tx_valid}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("single_hold", {7'd0, tx_valid, tx_data}, 16'h0141);
    end
    drain("single_drain");
    rd(BASE+1, v); chk("single_status", v, 16'h0009);

    // Overflow: ninth byte is dropped.
    for (int b = 1; b <= 9; b++) push(8'(b), b <= 8);
    rd(BASE+1, v); chk("ovf_status", v, 16'h080E);
    drain("ovf_drain");
    rd(BASE+1, v); chk("ovf_sticky", v, 16'h000D);
    wr(BASE+1, 16'h0004);
    rd(BASE+1, v); chk("ovf_clear", v, 16'h0009);

    // Push into a full FIFO on the same edge as a pop.
    for (int b = 0; b < 8; b++) push(8'(8'h10 + b), 1'b1);
    rd(BASE+1, v); chk("full_status", v, 16'h080A);
    addr = BASE; w_data = 16'h0055; w_en = 1'b1; tx_ready = 1'b1;
    exp_q.push_back(8'h55);
    cyc();
    w_en = 1'b0; tx_ready = 1'b0;
    rd(BASE+1, v); chk("full_pushpop", v, 16'h080A);
    drain("full_drain");

    // Drain disabled, then flush.
    wr(BASE+2, 16'h0000);
    tx_ready = 1'b1;
    for (int b = 0; b < 3; b++) push(8'(8'h60 + b), 1'b0);
    chk("nodrain_valid", {15'd0, tx_valid}, 16'd0);
    tx_ready = 1'b0;
    rd(BASE+1, v); chk("nodrain_status", v, 16'h0300);
    wr(BASE+2, 16'h0002);
    rd(BASE+1, v); chk("flush_status", v, 16'h0001);
    wr(BASE+2, 16'h0001);
    tx_ready = 1'b1;
    cyc();
    chk("flush_valid", {15'd0, tx_valid}, 16'd0);
    tx_ready = 1'b0;

    // Asynchronous reset in the middle of a drain.
    for (int b = 0; b < 3; b++) push(8'(8'h70 + b), 1'b1);
    rd(BASE+3, v); chk("pre_reset_scratch", v, 16'h5A5A);
    tx_ready = 1'b1;
    cyc();
    #2 reset = 1'b1;
    #1;
    chk("midreset_valid", {15'd0, tx_valid}, 16'd0);
    chk("midreset_rdata", r_data, 16'h0000);
    chk("midreset_txdata", {8'h00, tx_data}, 16'h0000);
    exp_q.delete();
    cyc();
    reset = 1'b0;
    tx_ready = 1'b0;
    rd(BASE+1, v); chk("post_reset_status", v, 16'h0009);
    rd(BASE+3, v); chk("post_reset_scratch", v, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmio_console_tx.md
Name: mmio_console_tx

Overview:
- Memory-mapped output peripheral; the responder side of the CPU's MAR/MDR memory interface.
- Decodes MAR addresses in a small window at BASE_ADDR and answers the same read/write enables the RAM uses.
- Byte writes are queued in an internal FIFO and drained to an external sink over a valid/ready byte stream.
- Top level muxes r_data between RAM and this block using sel.

Parameters:
- BASE_ADDR, 16'hFF00, word address of register 0; the window is 4 words (BASE_ADDR..BASE_ADDR+3).
- FIFO_DEPTH, 8, byte entries; must be a power of two, 2..64.
- CNT_W, 4, width of the occupancy count; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  16  word address from MAR.
- r_en  input  1  read enable, same strobe that drives RAM.
- w_en  input  1  write enable, same strobe that drives RAM.
- w_data  input  16  write data from MDR.
- r_data  output  16  registered read data to MDR mux.
- sel  output  1  combinational; 1 when addr is inside the window.
- tx_valid  output  1  stream byte available.
- tx_data  output  8  stream byte.
- tx_ready  input  1  sink accepts the byte.

Behaviour:
- Decode: sel = (addr[15:2] == BASE_ADDR[15:2]). Register offset = addr[1:0]. Accesses with sel=0 have no effect.
- Register map:
  - Offset 0, TXDATA (W): pushes w_data[7:0]; w_data[15:8] is ignored. Reads return 0.
  - Offset 1, STATUS (R/W1C):
    - bit0 empty.
    - bit1 full.
    - bit2 overflow, sticky.
    - bit3 drain_en, mirrored from CTRL.
    - bits[15:8] count, zero-extended.
    - Writing 1 to bit2 clears overflow. All other bits are read-only.
  - Offset 2, CTRL (R/W): bit0 drain_en, reset value 1. bit1 flush, self-clearing and reads as 0. Other bits read 0.
  - Offset 3, SCRATCH (R/W): 16-bit, reset 0.
- Reads: r_data is loaded on the rising edge where r_en=1 and sel=1, so it is valid one cycle later, matching RAM read latency. r_data holds its value until the next hit read.
- Writes: take effect on the rising edge where w_en=1 and sel=1. If r_en and w_en are both high in one cycle, the write wins and r_data is unchanged.
- FIFO: first-word fall-through.
  - tx_valid = drain_en & !empty.
  - tx_data = head entry. It must stay stable while tx_valid=1 and tx_ready=0.
  - Pop occurs on an edge with tx_valid & tx_ready.
- Push when not full: the byte is accepted and count is incremented.
- Push when full: the byte is accepted only if a pop happens on the same edge, in which case count is unchanged. Otherwise the byte is dropped and overflow is set.
- Simultaneous push and pop when empty: there is no pop, because tx_valid=0. The push is accepted and count becomes 1.
- Flush: count, read pointer and write pointer go to 0 on that edge. A TXDATA push in the same cycle is impossible, because flush and TXDATA are different offsets. A pop on the same edge is discarded.
- drain_en=0: tx_valid is forced to 0. The FIFO keeps filling.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Reset, asynchronous:
  - r_data=0, tx_valid=0, tx_data=0 (head RAM contents are don't-care but the output is gated to 0 when empty).
  - count=0, overflow=0, drain_en=1, scratch=0.
  - A reset mid-transfer drops all queued bytes.

Optional Feature:
- Macro MMIO_CONSOLE_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - Adds CTRL bit2 irq_en, reset 0.
  - irq is registered: it is set on the edge after (irq_en & (empty | overflow)) becomes true, and cleared on the edge after it becomes false.
  - irq resets to 0.
- When undefined: there is no irq port, and CTRL bit2 reads 0 and ignores writes.

Decomposition:
- Package mmio_console_pkg holds:
  - Register offset constants: OFF_TXDATA=0, OFF_STATUS=1, OFF_CTRL=2, OFF_SCRATCH=3.
  - STATUS bit index constants.
  - CTRL bit index constants.
- Sub-module sync_fifo, parameterised by width and depth:
  - Ports: push, pop, flush, din, dout, empty, full, count.
  - The top module holds decode, registers, overflow and stream gating.

Test Plan:
- Reset, then read STATUS at BASE+1: r_data=16'h0009 one cycle after the r_en edge (empty=1, drain_en=1). tx_valid=0.
- Hold tx_ready=0 and write 16'hAB41 to BASE+0: tx_valid=1, tx_data=8'h41. tx_data stays stable for 5 cycles. Raise tx_ready: the byte pops and STATUS reads 16'h0009.
- Hold tx_ready=0 and push 9 bytes 0x01..0x09 with FIFO_DEPTH=8: STATUS=16'h080E (count 8, full, overflow, drain_en). Drain yields 0x01..0x08; 0x09 is lost. Write 16'h0004 to BASE+1: overflow clears.
- With the FIFO full (tx_ready=0), push 0x55 while raising tx_ready on the same edge: the head pops, count stays 8, overflow stays 0, and 0x55 drains last.
- Write CTRL=0 and push 3 bytes: tx_valid stays 0 and count=3. Write CTRL=2 (flush): count=0 and empty=1. Write CTRL=1: tx_valid stays 0.
- Write 16'h1234 to BASE+4, which is outside the window: sel=0 and the SCRATCH read at BASE+3 is 0. Write 16'hBEEF to BASE+3 and read it back: r_data=16'hBEEF. Assert reset mid-drain: tx_valid=0 and r_data=0 immediately.
